// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM download writer: FSM state encoding and pad byte.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } rl_state_t;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/rom_loader.sv
// Writes an HPS download byte stream into a KB-kilobyte ROM, pads the unwritten
// tail with FILL_BYTE, and reports a running byte sum plus completion.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         KB    = 16,
  parameter logic [7:0] INDEX = 8'd0,
  localparam int        AW    = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dl_active,
  input  logic [7:0]    dl_index,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_d,
  output logic          mem_w,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [15:0]   sum,
  output rl_state_t     dbg_state
);

  localparam int            MEM_BYTES = KB * 1024;
  localparam logic [AW:0]   MEM_END   = (AW + 1)'(MEM_BYTES);
  localparam logic [AW-1:0] LAST_A    = AW'(MEM_BYTES - 1);

  // Handshake: a memory write transfers on every rising edge where mem_w and
  // mem_ready are both high; mem_a/mem_d/mem_w stay stable until that edge.
  // The source must not strobe dl_wr while dl_wait is high.

  rl_state_t     state, state_n;
  logic [AW-1:0] mem_a_n;
  logic [7:0]    mem_d_n;
  logic [15:0]   sum_n;
  logic [AW:0]   hwm, hwm_n;
  logic          overrun_n;
  logic          mem_w_n, dl_wait_n, busy_n, done_n;

  logic          start_hit;
  logic          byte_ok;
  logic [AW:0]   addr_p1;

  assign start_hit = dl_active && (dl_index == INDEX);
  assign byte_ok   = dl_wr && (dl_index == INDEX) && (dl_addr < 25'(MEM_BYTES));
  assign addr_p1   = {1'b0, dl_addr[AW-1:0]} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_n   = state;
    mem_a_n   = mem_a;
    mem_d_n   = mem_d;
    sum_n     = sum;
    hwm_n     = hwm;
    overrun_n = overrun;

    case (state)
      IDLE, DONE: begin
        if (start_hit) begin
          state_n   = LOAD;
          sum_n     = '0;
          hwm_n     = '0;
          overrun_n = 1'b0;
        end
      end
      LOAD: begin
        // A strobe wins over the end of download so the last byte is never lost.
        if (byte_ok) begin
          state_n = WRITE;
          mem_a_n = dl_addr[AW-1:0];
          mem_d_n = dl_data;
          sum_n   = sum + {8'h00, dl_data};
          if (addr_p1 > hwm) hwm_n = addr_p1;
        end else if (!dl_active) begin
          mem_a_n = hwm[AW-1:0];
          mem_d_n = FILL_BYTE;
          state_n = (hwm < MEM_END) ? FILL : DONE;
        end
      end
      WRITE: begin
        if (dl_wr) overrun_n = 1'b1;
        if (mem_ready) state_n = LOAD;
      end
      FILL: begin
        if (mem_ready) begin
          if (mem_a == LAST_A) state_n = DONE;
          else                 mem_a_n = mem_a + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: state_n = IDLE;
    endcase

    // Flag outputs are registered copies of the next-state decode.
    mem_w_n   = (state_n == WRITE) || (state_n == FILL);
    dl_wait_n = (state_n == WRITE);
    busy_n    = (state_n == LOAD) || (state_n == WRITE) || (state_n == FILL);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      mem_a   <= '0;
      mem_d   <= FILL_BYTE;
      mem_w   <= 1'b0;
      dl_wait <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      sum     <= '0;
      hwm     <= '0;
    end else begin
      state   <= state_n;
      mem_a   <= mem_a_n;
      mem_d   <= mem_d_n;
      mem_w   <= mem_w_n;
      dl_wait <= dl_wait_n;
      busy    <= busy_n;
      done    <= done_n;
      overrun <= overrun_n;
      sum     <= sum_n;
      hwm     <= hwm_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: drives HPS-style downloads and checks every memory
// write, the final image, the byte sum and the status flags against a model.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int         KB        = 1;
  localparam logic [7:0] IDX       = 8'd3;
  localparam int         MEM_BYTES = KB * 1024;
  localparam int         AW        = $clog2(MEM_BYTES);
  localparam int         W         = AW + 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          dl_active = 1'b0;
  logic [7:0]    dl_index  = 8'd0;
  logic          dl_wr     = 1'b0;
  logic [24:0]   dl_addr   = '0;
  logic [7:0]    dl_data   = '0;
  logic          dl_wait;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_d;
  logic          mem_w;
  logic          mem_ready = 1'b1;
  logic          busy, done, overrun;
  logic [15:0]   sum;
  rl_state_t     dbg_state;

  rom_loader #(.KB(KB), .INDEX(IDX)) dut (
    .clock(clock), .reset(reset),
    .dl_active(dl_active), .dl_index(dl_index), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .mem_a(mem_a), .mem_d(mem_d), .mem_w(mem_w), .mem_ready(mem_ready),
    .busy(busy), .done(done), .overrun(overrun), .sum(sum),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  tb_mem [MEM_BYTES];
  logic [7:0]  exp_img[MEM_BYTES];
  int          exp_sum     = 0;
  int          exp_hwm     = 0;
  logic        exp_overrun = 1'b0;
  int          ready_mode  = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(0, 3) != 0);
      default: mem_ready = 1'b0;
    endcase
  end

  // Parent memory plus write-stream scoreboard; the write lands on the next edge.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (mem_w === 1'b1 && mem_ready === 1'b1) begin
      tb_mem[mem_a] = mem_d;
      chk("write_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", mem_a, e[W-1:8]);
        chk("write_data", mem_d, e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    dl_index  = idx;
    dl_active = 1'b1;
    step();
    step();
    if (idx == IDX) begin
      exp_sum     = 0;
      exp_hwm     = 0;
      exp_overrun = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
    end
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    int guard = 0;
    logic [AW-1:0] a;
    while (dl_wait && guard < 200) begin
      step();
      guard++;
    end
    chk("src_wait_bound", (guard < 200), 1);
    dl_addr = addr;
    dl_data = data;
    dl_wr   = 1'b1;
    step();
    dl_wr = 1'b0;
    if (addr < MEM_BYTES) begin
      a = addr[AW-1:0];
      exp_q.push_back({a, data});
      exp_img[a] = data;
      exp_sum    = (exp_sum + int'(data)) % 65536;
      if (int'(addr) + 1 > exp_hwm) exp_hwm = int'(addr) + 1;
      chk("strobe_mem_w", mem_w, 1);
      chk("strobe_dl_wait", dl_wait, 1);
    end else begin
      chk("oob_mem_w", mem_w, 0);
      chk("oob_dl_wait", dl_wait, 0);
    end
  endtask

  task automatic push_fill();
    logic [AW-1:0] a;
    for (int i = exp_hwm; i < MEM_BYTES; i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, FILL_BYTE});
    end
  endtask

  task automatic end_dl(input bit settle, input bit timed);
    int guard = 0;
    int cyc   = 0;
    int bad   = 0;
    while (settle && dl_wait && guard < 200) begin
      step();
      guard++;
    end
    dl_active = 1'b0;
    push_fill();
    while (!done && cyc < 4 * MEM_BYTES) begin
      step();
      cyc++;
    end
    chk("done_reached", done, 1);
    if (timed) chk("fill_cycles", cyc, MEM_BYTES - exp_hwm + 1);
    for (int i = exp_hwm; i < MEM_BYTES; i++) exp_img[i] = FILL_BYTE;
    chk("queue_drained", exp_q.size(), 0);
    chk("sum", sum, exp_sum);
    chk("overrun", overrun, exp_overrun);
    chk("busy_done", busy, 0);
    chk("mem_w_done", mem_w, 0);
    chk("state_done", dbg_state, DONE);
    for (int i = 0; i < MEM_BYTES; i++) if (tb_mem[i] !== exp_img[i]) bad++;
    chk("image_mismatches", bad, 0);
  endtask

  task automatic foreign_dl(input rl_state_t st, input logic d);
    start_dl(8'h00);
    for (int i = 0; i < 4; i++) begin
      dl_addr = 25'(i);
      dl_data = 8'(i + 8'h40);
      dl_wr   = 1'b1;
      step();
      dl_wr = 1'b0;
      step();
    end
    chk("foreign_state", dbg_state, st);
    chk("foreign_done", done, d);
    chk("foreign_wait", dl_wait, 0);
    chk("foreign_sum", sum, exp_sum);
    dl_active = 1'b0;
    step();
  endtask

  task automatic check_reset_values();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_dl_wait", dl_wait, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 8'hFF);
    chk("rst_mem_w", mem_w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sum", sum, 0);
  endtask

  task automatic random_dl(input int nbytes);
    start_dl(IDX);
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 7) == 0)
        send_byte(25'(MEM_BYTES + $urandom_range(0, 100)), 8'($urandom));
      else
        send_byte(25'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
    end
    end_dl(1'b1, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    for (int i = 0; i < MEM_BYTES; i++) begin
      tb_mem[i]  = 8'hA5;
      exp_img[i] = 8'hA5;
    end
    reset = 1'b0;
    repeat (3) step();
    check_reset_values();
    reset = 1'b1;
    step();

    // foreign download from IDLE
    foreign_dl(IDLE, 1'b0);

    // full image, no fill
    start_dl(IDX);
    for (int i = 0; i < MEM_BYTES; i++) send_byte(25'(i), 8'(i % 256));
    end_dl(1'b1, 1'b1);

    // foreign download from DONE
    foreign_dl(DONE, 1'b1);

    // three bytes then padding
    start_dl(IDX);
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    send_byte(25'd2, 8'h56);
    send_byte(25'(MEM_BYTES), 8'h99);
    end_dl(1'b1, 1'b1);

    // out-of-order addresses
    start_dl(IDX);
    send_byte(25'd10, 8'hC3);
    send_byte(25'd4, 8'h3C);
    end_dl(1'b1, 1'b1);

    // memory stall, overrun strobe, download ends mid-write
    ready_mode = 2;
    start_dl(IDX);
    send_byte(25'd0, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_w", mem_w, 1);
      chk("stall_dl_wait", dl_wait, 1);
      if (i == 1) begin
        dl_addr     = 25'd1;
        dl_data     = 8'h77;
        dl_wr       = 1'b1;
        exp_overrun = 1'b1;
      end
      step();
      dl_wr = 1'b0;
    end
    ready_mode = 0;
    end_dl(1'b0, 1'b0);

    // reset during FILL at address 500
    start_dl(IDX);
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    send_byte(25'd2, 8'h03);
    guard = 0;
    while (dl_wait && guard < 200) begin
      step();
      guard++;
    end
    dl_active = 1'b0;
    push_fill();
    guard = 0;
    while (!(mem_w && mem_a == AW'(500)) && guard < 2 * MEM_BYTES) begin
      step();
      guard++;
    end
    chk("fill_reaches_500", (guard < 2 * MEM_BYTES), 1);
    reset = 1'b0;
    step();
    check_reset_values();
    exp_q.delete();
    for (int i = 3; i <= 500; i++) exp_img[i] = FILL_BYTE;
    exp_sum = 0;
    reset = 1'b1;
    step();

    // randomized downloads with a jittery memory
    ready_mode = 1;
    for (int r = 0; r < 5; r++) random_dl($urandom_range(1, 40));
    ready_mode = 0;
    random_dl(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
